// File: rtl/fb_triple_sched.sv
// Triple-buffer frame scheduler: rotates write/ready/read ownership of three
// frame buffers on writer and reader start-of-frame pulses.
module fb_triple_sched #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    soft_resetn,
  input  logic [C_ADDR_WIDTH-1:0] buf0_addr,
  input  logic [C_ADDR_WIDTH-1:0] buf1_addr,
  input  logic [C_ADDR_WIDTH-1:0] buf2_addr,
  input  logic                    w_sof,
  output logic [1:0]              w_idx,
  output logic [C_ADDR_WIDTH-1:0] w_addr,
  input  logic                    r_sof,
  output logic [1:0]              r_idx,
  output logic [C_ADDR_WIDTH-1:0] r_addr,
  output logic                    r_valid,
  output logic                    r_repeat,
  output logic [C_CNT_WIDTH-1:0]  drop_cnt,
  output logic [C_CNT_WIDTH-1:0]  repeat_cnt
);

  logic [1:0]             w_q, d_q, r_q, w_n, d_n, r_n;
  logic                   dv_q, dv_n, busy_q, busy_n, rv_q, rv_n, rrep_q, rrep_n;
  logic [C_CNT_WIDTH-1:0] drop_q, drop_n, rep_q, rep_n;

  // Writer step first, reader step sees its result so a frame completed in
  // the same cycle goes straight to the reader.
  always_comb begin
    w_n    = w_q;
    d_n    = d_q;
    r_n    = r_q;
    dv_n   = dv_q;
    busy_n = busy_q;
    rv_n   = rv_q;
    rrep_n = rrep_q;
    drop_n = drop_q;
    rep_n  = rep_q;
    if (w_sof) begin
      if (!busy_q) begin
        busy_n = 1'b1;
      end else begin
        if (dv_q) drop_n = drop_q + 1'b1;
        w_n  = d_q;
        d_n  = w_q;
        dv_n = 1'b1;
      end
    end
    if (r_sof) begin
      if (dv_n) begin
        r_n    = d_n;
        d_n    = r_q;
        dv_n   = 1'b0;
        rv_n   = 1'b1;
        rrep_n = 1'b0;
      end else begin
        rrep_n = 1'b1;
        rep_n  = rep_q + 1'b1;
      end
    end
    if (!soft_resetn) begin
      w_n    = 2'd0;
      r_n    = 2'd1;
      d_n    = 2'd2;
      dv_n   = 1'b0;
      busy_n = 1'b0;
      rv_n   = 1'b0;
      rrep_n = 1'b0;
      drop_n = '0;
      rep_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_q    <= 2'd0;
      r_q    <= 2'd1;
      d_q    <= 2'd2;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
      rv_q   <= 1'b0;
      rrep_q <= 1'b0;
      drop_q <= '0;
      rep_q  <= '0;
    end else begin
      w_q    <= w_n;
      r_q    <= r_n;
      d_q    <= d_n;
      dv_q   <= dv_n;
      busy_q <= busy_n;
      rv_q   <= rv_n;
      rrep_q <= rrep_n;
      drop_q <= drop_n;
      rep_q  <= rep_n;
    end
  end

  function automatic logic [C_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    addr_of = buf0_addr;
      2'd1:    addr_of = buf1_addr;
      default: addr_of = buf2_addr;
    endcase
  endfunction

  // Base addresses are static, so muxing off the registered index keeps
  // the addresses effectively registered while tracking the inputs.
  assign w_idx      = w_q;
  assign r_idx      = r_q;
  assign w_addr     = addr_of(w_q);
  assign r_addr     = addr_of(r_q);
  assign r_valid    = rv_q;
  assign r_repeat   = rrep_q;
  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;

  a_perm: assert property (@(posedge clk) disable iff (!resetn)
    (w_q != d_q) && (w_q != r_q) && (d_q != r_q));

endmodule

// File: tb/tb_fb_triple_sched.sv
// Randomized and directed bench for fb_triple_sched against an ownership model.
module tb_fb_triple_sched;
  localparam int AW = 32;
  localparam int CW = 8;

  logic          clk, resetn, soft_resetn, w_sof, r_sof;
  logic [AW-1:0] buf0_addr, buf1_addr, buf2_addr, w_addr, r_addr;
  logic [1:0]    w_idx, r_idx;
  logic          r_valid, r_repeat;
  logic [CW-1:0] drop_cnt, repeat_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  fb_triple_sched #(.C_ADDR_WIDTH(AW), .C_CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .soft_resetn(soft_resetn),
    .buf0_addr(buf0_addr), .buf1_addr(buf1_addr), .buf2_addr(buf2_addr),
    .w_sof(w_sof), .w_idx(w_idx), .w_addr(w_addr),
    .r_sof(r_sof), .r_idx(r_idx), .r_addr(r_addr),
    .r_valid(r_valid), .r_repeat(r_repeat),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner[b] says who holds buffer b (0=writer, 1=ready, 2=reader).
  typedef struct {
    int owner[3];
    bit fresh;     // ready buffer holds an unread frame
    bit started;   // writer has begun a frame
    bit rv, rrep;
    int drops, reps;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t m_reset();
    mdl_t s;
    s.owner[0] = 0; s.owner[1] = 2; s.owner[2] = 1;
    s.fresh = 0; s.started = 0; s.rv = 0; s.rrep = 0;
    s.drops = 0; s.reps = 0;
    return s;
  endfunction

  function automatic int holder(mdl_t s, int role);
    for (int b = 0; b < 3; b++) if (s.owner[b] == role) return b;
    return -1;
  endfunction

  function automatic mdl_t m_step(mdl_t s, bit ws, bit rs);
    mdl_t n = s;
    if (ws) begin
      if (!n.started) n.started = 1;
      else begin
        int wb = holder(n, 0), rb = holder(n, 1);
        if (n.fresh) n.drops++;
        n.owner[wb] = 1; n.owner[rb] = 0; n.fresh = 1;
      end
    end
    if (rs) begin
      if (n.fresh) begin
        int db = holder(n, 1), xb = holder(n, 2);
        n.owner[db] = 2; n.owner[xb] = 1; n.fresh = 0; n.rv = 1; n.rrep = 0;
      end else begin
        n.rrep = 1; n.reps++;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn)           m <= m_reset();
    else if (!soft_resetn) m <= m_reset();
    else                   m <= m_step(m, w_sof, r_sof);
  end

  function automatic logic [AW-1:0] baddr(int b);
    return (b == 0) ? buf0_addr : (b == 1) ? buf1_addr : buf2_addr;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("m_w_idx",  64'(w_idx),      64'(holder(m, 0)));
    chk("m_r_idx",  64'(r_idx),      64'(holder(m, 2)));
    chk("m_w_addr", 64'(w_addr),     64'(baddr(holder(m, 0))));
    chk("m_r_addr", 64'(r_addr),     64'(baddr(holder(m, 2))));
    chk("m_rvalid", 64'(r_valid),    64'(m.rv));
    chk("m_rrep",   64'(r_repeat),   64'(m.rrep));
    chk("m_drop",   64'(drop_cnt),   64'(m.drops % (1 << CW)));
    chk("m_rep",    64'(repeat_cnt), 64'(m.reps % (1 << CW)));
  end

  // Pulse then land on the negedge where the result is visible.
  task automatic pulse(input bit ws, input bit rs);
    @(negedge clk); w_sof = ws; r_sof = rs;
    @(negedge clk); w_sof = 0;  r_sof = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic soft_rst();
    @(negedge clk); soft_resetn = 0;
    @(negedge clk); soft_resetn = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_widx"},  64'(w_idx), 64'd0);
    chk({tag, "_ridx"},  64'(r_idx), 64'd1);
    chk({tag, "_rv"},    64'(r_valid), 64'd0);
    chk({tag, "_rrep"},  64'(r_repeat), 64'd0);
    chk({tag, "_waddr"}, 64'(w_addr), 64'(buf0_addr));
    chk({tag, "_raddr"}, 64'(r_addr), 64'(buf1_addr));
    chk({tag, "_drop"},  64'(drop_cnt), 64'd0);
    chk({tag, "_rep"},   64'(repeat_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0; soft_resetn = 1; w_sof = 0; r_sof = 0;
    buf0_addr = 32'h1000_0000; buf1_addr = 32'h2000_0000; buf2_addr = 32'h3000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1; chk_en = 1;
    idle(2);
    chk_reset_vals("rst");

    // Reader before any frame: repeat.
    pulse(0, 1);
    chk("rep_ridx", 64'(r_idx), 64'd1);
    chk("rep_flag", 64'(r_repeat), 64'd1);
    chk("rep_cnt",  64'(repeat_cnt), 64'd1);
    chk("rep_rv",   64'(r_valid), 64'd0);

    soft_rst();
    chk_reset_vals("srst1");

    // Two writer frames then a read.
    pulse(1, 0); idle(3);
    chk("w1_widx", 64'(w_idx), 64'd0);
    pulse(1, 0); idle(3);
    chk("w2_widx", 64'(w_idx), 64'd2);
    chk("w2_ridx", 64'(r_idx), 64'd1);
    pulse(0, 1);
    chk("rd_ridx",  64'(r_idx), 64'd0);
    chk("rd_raddr", 64'(r_addr), 64'(buf0_addr));
    chk("rd_rv",    64'(r_valid), 64'd1);
    chk("rd_rrep",  64'(r_repeat), 64'd0);

    soft_rst();
    // Four writes, no reads: two drops.
    pulse(1, 0); chk("d1_widx", 64'(w_idx), 64'd0);
    pulse(1, 0); chk("d2_widx", 64'(w_idx), 64'd2);
    pulse(1, 0); chk("d3_widx", 64'(w_idx), 64'd0);
    chk("d3_ridx", 64'(r_idx), 64'd1);
    pulse(1, 0);
    chk("d4_drop", 64'(drop_cnt), 64'd2);
    chk("d4_ridx", 64'(r_idx), 64'd1);

    soft_rst();
    // Simultaneous sofs with writer busy and no ready frame.
    pulse(1, 0); idle(2);
    pulse(1, 1);
    chk("sim_ridx", 64'(r_idx), 64'd0);
    chk("sim_widx", 64'(w_idx), 64'd2);
    chk("sim_drop", 64'(drop_cnt), 64'd0);
    chk("sim_rep",  64'(repeat_cnt), 64'd0);
    chk("sim_rv",   64'(r_valid), 64'd1);

    // Soft reset mid-sequence, then first write only arms the writer.
    pulse(1, 0);
    soft_rst();
    chk_reset_vals("srst2");
    pulse(1, 0);
    chk("sr_w1", 64'(w_idx), 64'd0);
    pulse(1, 0);
    chk("sr_w2", 64'(w_idx), 64'd2);

    // Async reset between clock edges.
    pulse(0, 1); pulse(1, 0);
    @(posedge clk); #2 resetn = 0; #1;
    chk_reset_vals("arst");
    @(negedge clk); resetn = 1;
    pulse(1, 0);
    chk("ar_w1", 64'(w_idx), 64'd0);
    pulse(1, 0);
    chk("ar_w2", 64'(w_idx), 64'd2);

    // Random traffic; long enough for drop_cnt to wrap.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      w_sof = ($urandom_range(0, 1) == 0);
      r_sof = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      w_sof = ($urandom_range(0, 2) == 0);
      r_sof = ($urandom_range(0, 2) == 0);
      soft_resetn = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk); w_sof = 0; r_sof = 0; soft_resetn = 1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
